// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, memory request
// bundle and grant-mux select.
package dmem_arb_pkg;

  // Widths of the request bundle; ports narrower than this are zero-extended.
  localparam int ARB_ADDR_W = 16;
  localparam int ARB_DATA_W = 16;

  // Width of the optional performance counters.
  localparam int PERF_W = 16;

  typedef enum logic {
    IDLE     = 1'b0,
    P1_BURST = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_P0   = 2'd1,
    SEL_P1   = 2'd2
  } grant_sel_e;

  typedef struct packed {
    logic                  we;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear. A cycle with both clr and
// inc lands on 1, which is how a fresh burst loads its first beat.
module arb_sat_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);

  logic [WIDTH-1:0] countReg;
  logic [WIDTH-1:0] countNext;

  // Clear first, then a saturating increment on top of the cleared value.
  always_comb begin
    countNext = countReg;
    if (clr) begin
      countNext = '0;
    end
    if (inc && (countNext != MaxVal)) begin
      countNext = countNext + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      countReg <= '0;
    end else begin
      countReg <= countNext;
    end
  end

  assign count  = countReg;
  assign at_max = (countReg == MaxVal);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single data memory. Port 0 (pipeline MEM
// stage) has fixed priority; port 1 (loader/debug DMA) is protected from
// starvation by an aging counter and may hold the memory for a locked burst.
// Optional macro DMEM_ARB_PERF_EN adds saturating performance counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 8,
  parameter int MAX_BURST    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_stall,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic              p1_lock,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_conflict,
  output logic [PERF_W-1:0] perf_p0_stall,
  output logic [PERF_W-1:0] perf_forced
`endif
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam int BEAT_W   = $clog2(MAX_BURST + 1);

  arb_state_e          stateReg;
  arb_state_e          stateNext;
  grant_sel_e          grantSel;
  logic [STARVE_W-1:0] starveCnt;
  logic                starveAtMax;
  logic [BEAT_W-1:0]   beatCnt;
  logic                beatAtMax;
  logic                lastBeat;
  logic                p1Gnt;
  logic                enterBurst;
  mem_req_t            p0Bus;
  mem_req_t            p1Bus;
  mem_req_t            memBus;

  // beatCnt holds beats already granted in this burst, so the beat granted
  // while it reads MAX_BURST-1 is the final one.
  assign lastBeat = (beatCnt == BEAT_W'(MAX_BURST - 1));

  // Grant decision and next state; nothing is granted while reset is high.
  always_comb begin
    grantSel  = SEL_NONE;
    stateNext = stateReg;
    if (!reset) begin
      case (stateReg)
        IDLE: begin
          if (p0_req && !(p1_req && starveAtMax)) begin
            grantSel = SEL_P0;
          end else if (p1_req) begin
            grantSel = SEL_P1;
            // A one-beat burst limit means a locked beat is already the last.
            if (p1_lock && (MAX_BURST > 1)) begin
              stateNext = P1_BURST;
            end
          end
        end
        P1_BURST: begin
          if (p1_req) begin
            grantSel = SEL_P1;
            if (!p1_lock || lastBeat) begin
              stateNext = IDLE;
            end
          end else begin
            stateNext = IDLE;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // State register; reset abandons any burst in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  assign p1Gnt      = (grantSel == SEL_P1);
  assign enterBurst = (stateReg == IDLE) && (stateNext == P1_BURST);

  arb_sat_counter #(.WIDTH(STARVE_W), .MAX(STARVE_LIMIT)) uStarve (
    .clk    (clk),
    .reset  (reset),
    .inc    (p1_req & ~p1Gnt),
    .clr    (p1Gnt),
    .count  (starveCnt),
    .at_max (starveAtMax)
  );

  arb_sat_counter #(.WIDTH(BEAT_W), .MAX(MAX_BURST)) uBeat (
    .clk    (clk),
    .reset  (reset),
    .inc    (p1Gnt & p1_lock),
    .clr    (enterBurst),
    .count  (beatCnt),
    .at_max (beatAtMax)
  );

  assign p0Bus = '{we: p0_we, addr: ARB_ADDR_W'(p0_addr), wdata: ARB_DATA_W'(p0_wdata)};
  assign p1Bus = '{we: p1_we, addr: ARB_ADDR_W'(p1_addr), wdata: ARB_DATA_W'(p1_wdata)};

  // Memory-side mux; the bus is all zeros when nobody is granted.
  always_comb begin
    memBus = '0;
    case (grantSel)
      SEL_P0:  memBus = p0Bus;
      SEL_P1:  memBus = p1Bus;
      default: memBus = '0;
    endcase
  end

  assign p0_gnt    = (grantSel == SEL_P0);
  assign p1_gnt    = p1Gnt;
  assign p0_stall  = p0_req & ~p0_gnt & ~reset;
  assign mem_addr  = ADDR_W'(memBus.addr);
  assign mem_wdata = DATA_W'(memBus.wdata);
  assign mem_we    = (grantSel != SEL_NONE) & memBus.we;
  assign mem_re    = (grantSel != SEL_NONE) & ~memBus.we;
  assign rdata     = mem_re ? mem_rdata : '0;

`ifdef DMEM_ARB_PERF_EN
  logic forcedGrant;
  logic conflictSat;
  logic stallSat;
  logic forcedSat;
  logic unusedBits;

  // A p1 grant in IDLE while p0 is asking can only come from the aging override.
  assign forcedGrant = p1Gnt & p0_req & (stateReg == IDLE);

  arb_sat_counter #(.WIDTH(PERF_W), .MAX(65535)) uPerfConflict (
    .clk (clk), .reset (reset), .inc (p0_req & p1_req), .clr (1'b0),
    .count (perf_conflict), .at_max (conflictSat)
  );
  arb_sat_counter #(.WIDTH(PERF_W), .MAX(65535)) uPerfStall (
    .clk (clk), .reset (reset), .inc (p0_stall), .clr (1'b0),
    .count (perf_p0_stall), .at_max (stallSat)
  );
  arb_sat_counter #(.WIDTH(PERF_W), .MAX(65535)) uPerfForced (
    .clk (clk), .reset (reset), .inc (forcedGrant), .clr (1'b0),
    .count (perf_forced), .at_max (forcedSat)
  );

  // Counter outputs this block has no use for.
  assign unusedBits = &{1'b0, starveCnt, beatAtMax, conflictSat, stallSat, forcedSat};
`else
  logic unusedBits;

  // Counter outputs this block has no use for.
  assign unusedBits = &{1'b0, starveCnt, beatAtMax};
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
// Build with DMEM_ARB_PERF_EN defined to also check the perf counters.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int STARVE_LIMIT = 8;
  localparam int MAX_BURST    = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p0_gnt, p0_stall;
  logic [15:0] p0_addr, p0_wdata;
  logic        p1_req, p1_we, p1_lock, p1_gnt;
  logic [15:0] p1_addr, p1_wdata;
  logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re;
`ifdef DMEM_ARB_PERF_EN
  logic [15:0] perf_conflict, perf_p0_stall, perf_forced;
`endif

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(STARVE_LIMIT), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_stall(p0_stall),
    .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_gnt(p1_gnt),
    .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    , .perf_conflict(perf_conflict), .perf_p0_stall(perf_p0_stall), .perf_forced(perf_forced)
`endif
  );

  // Data memory: combinational read, write on the rising edge.
  logic [15:0] mem [256];
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  end

  int nChecks = 0;
  int nFails  = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%04h expected 0x%04h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: how long p1 has waited, how many beats of a locked run
  // p1 has taken, and the grants it predicted last cycle.
  int          waitCnt    = 0;
  int          burstBeats = 0;
  bit          lastG0     = 1'b0;
  bit          lastG1     = 1'b0;
  logic [15:0] mConflict  = 16'd0;
  logic [15:0] mStall     = 16'd0;
  logic [15:0] mForced    = 16'd0;

  always @(negedge clk) begin : cmp
    bit          g0, g1, st, ewe, ere, forced;
    logic [15:0] ea, ew, er;
    g0 = 1'b0;
    g1 = 1'b0;
    if (!reset) begin
      if (burstBeats > 0)                                       g1 = p1_req;
      else if (p0_req && !(p1_req && waitCnt >= STARVE_LIMIT))  g0 = 1'b1;
      else                                                      g1 = p1_req;
    end
    forced = g1 && p0_req && (burstBeats == 0);
    st  = p0_req && !g0 && !reset;
    ea  = 16'h0; ew = 16'h0; ewe = 1'b0; ere = 1'b0;
    if (g0) begin ea = p0_addr; ew = p0_wdata; ewe = p0_we; ere = !p0_we; end
    if (g1) begin ea = p1_addr; ew = p1_wdata; ewe = p1_we; ere = !p1_we; end
    er = ere ? mem[ea[7:0]] : 16'h0;

    chk1("p0_gnt", p0_gnt, g0);
    chk1("p1_gnt", p1_gnt, g1);
    chk1("p0_stall", p0_stall, st);
    chk1("mem_we", mem_we, ewe);
    chk1("mem_re", mem_re, ere);
    chk16("mem_addr", mem_addr, ea);
    chk16("mem_wdata", mem_wdata, ew);
    chk16("rdata", rdata, er);
`ifdef DMEM_ARB_PERF_EN
    chk16("perf_conflict", perf_conflict, mConflict);
    chk16("perf_p0_stall", perf_p0_stall, mStall);
    chk16("perf_forced", perf_forced, mForced);
`endif

    if (reset) begin
      waitCnt    <= 0;
      burstBeats <= 0;
      mConflict  <= 16'd0;
      mStall     <= 16'd0;
      mForced    <= 16'd0;
    end else begin
      if (p0_req && p1_req && mConflict != 16'hFFFF) mConflict <= mConflict + 16'd1;
      if (st && mStall != 16'hFFFF)                  mStall    <= mStall + 16'd1;
      if (forced && mForced != 16'hFFFF)             mForced   <= mForced + 16'd1;
      if (g1) begin
        waitCnt    <= 0;
        burstBeats <= (p1_lock && (burstBeats + 1 < MAX_BURST)) ? burstBeats + 1 : 0;
      end else begin
        if (p1_req && waitCnt < STARVE_LIMIT) waitCnt <= waitCnt + 1;
        burstBeats <= 0;
      end
    end
    lastG0 <= g0;
    lastG1 <= g1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setP0(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    p0_req = r; p0_we = w; p0_addr = a; p0_wdata = d;
  endtask

  task automatic setP1(input logic r, input logic w, input logic l,
                       input logic [15:0] a, input logic [15:0] d);
    p1_req = r; p1_we = w; p1_lock = l; p1_addr = a; p1_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);
    mem[8'h10] = 16'h1234;

    // Reset with both ports requesting: nothing may be granted.
    reset = 1'b1;
    setP0(1'b1, 1'b0, 16'h0010, 16'h0);
    setP1(1'b1, 1'b1, 1'b1, 16'h0050, 16'hBEEF);
    @(negedge clk);
    chk1("rst_p0_gnt", p0_gnt, 1'b0);
    chk1("rst_p1_gnt", p1_gnt, 1'b0);
    chk1("rst_p0_stall", p0_stall, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    tick();

    // Scenario 1: lone p0 load from 0x0010.
    reset = 1'b0;
    setP1(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    setP0(1'b1, 1'b0, 16'h0010, 16'h0);
    @(negedge clk);
    chk1("s1_p0_gnt", p0_gnt, 1'b1);
    chk1("s1_mem_re", mem_re, 1'b1);
    chk16("s1_rdata", rdata, 16'h1234);
    chk1("s1_p0_stall", p0_stall, 1'b0);
    tick();

    // Scenario 2: both ports request continuously; p1 forced on cycle 9.
    setP0(1'b1, 1'b0, 16'h0030, 16'h0);
    setP1(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i < 8) begin
        chk1("s2_p0_gnt", p0_gnt, 1'b1);
        chk1("s2_p1_wait", p1_gnt, 1'b0);
      end else begin
        chk1("s2_p1_forced", p1_gnt, 1'b1);
        chk1("s2_p0_stall", p0_stall, 1'b1);
      end
      tick();
    end
    setP1(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    chk1("s2_p0_after", p0_gnt, 1'b1);
`ifdef DMEM_ARB_PERF_EN
    chk16("s6_perf_conflict", perf_conflict, 16'd9);
    chk16("s6_perf_p0_stall", perf_p0_stall, 16'd1);
    chk16("s6_perf_forced", perf_forced, 16'd1);
`endif
    tick();
    setP0(1'b0, 1'b0, 16'h0, 16'h0);

    // Scenario 3: six locked writes; burst capped at four, p0 then served.
    setP1(1'b1, 1'b1, 1'b1, 16'h0100, 16'hA000);
    @(negedge clk);
    chk1("s3_beat1", p1_gnt, 1'b1);
    tick();
    setP0(1'b1, 1'b0, 16'h0010, 16'h0);
    for (int k = 1; k < 4; k++) begin
      setP1(1'b1, 1'b1, 1'b1, 16'(16'h0100 + k), 16'(16'hA000 + k));
      @(negedge clk);
      chk1("s3_beat", p1_gnt, 1'b1);
      chk1("s3_p0_stall", p0_stall, 1'b1);
      tick();
    end
    setP1(1'b1, 1'b1, 1'b1, 16'h0104, 16'hA004);
    @(negedge clk);
    chk1("s3_p0_gnt", p0_gnt, 1'b1);
    chk1("s3_p1_held", p1_gnt, 1'b0);
    chk16("s3_rdata", rdata, 16'h1234);
    tick();
    setP0(1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    chk1("s3_beat5", p1_gnt, 1'b1);
    tick();
    setP1(1'b1, 1'b1, 1'b0, 16'h0105, 16'hA005);
    @(negedge clk);
    chk1("s3_beat6", p1_gnt, 1'b1);
    tick();
    setP1(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int k = 0; k < 6; k++) chk16("s3_memdata", mem[8'h00 + k], 16'(16'hA000 + k));

    // Scenario 4: p0 store arrives mid-burst, served once lock drops.
    setP1(1'b1, 1'b0, 1'b1, 16'h0200, 16'h0);
    @(negedge clk);
    chk1("s4_beat1", p1_gnt, 1'b1);
    tick();
    setP1(1'b1, 1'b0, 1'b1, 16'h0201, 16'h0);
    setP0(1'b1, 1'b1, 16'h0040, 16'h5555);
    @(negedge clk);
    chk1("s4_beat2", p1_gnt, 1'b1);
    chk1("s4_stall2", p0_stall, 1'b1);
    tick();
    setP1(1'b1, 1'b0, 1'b0, 16'h0202, 16'h0);
    @(negedge clk);
    chk1("s4_beat3", p1_gnt, 1'b1);
    chk1("s4_stall3", p0_stall, 1'b1);
    tick();
    setP1(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    chk1("s4_p0_gnt", p0_gnt, 1'b1);
    chk1("s4_mem_we", mem_we, 1'b1);
    tick();
    setP0(1'b0, 1'b0, 16'h0, 16'h0);
    chk16("s4_store", mem[8'h40], 16'h5555);

    // Scenario 5: reset during beat 2 abandons the burst.
    setP1(1'b1, 1'b0, 1'b1, 16'h0300, 16'h0);
    @(negedge clk);
    chk1("s5_beat1", p1_gnt, 1'b1);
    tick();
    reset = 1'b1;
    setP1(1'b1, 1'b0, 1'b1, 16'h0301, 16'h0);
    setP0(1'b1, 1'b0, 16'h0010, 16'h0);
    @(negedge clk);
    chk1("s5_rst_p1", p1_gnt, 1'b0);
    chk1("s5_rst_p0", p0_gnt, 1'b0);
    chk1("s5_rst_stall", p0_stall, 1'b0);
    chk1("s5_rst_re", mem_re, 1'b0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk1("s5_p0_gnt", p0_gnt, 1'b1);
    chk1("s5_p1_wait", p1_gnt, 1'b0);
    tick();
    setP0(1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    chk1("s5_p1_rearb", p1_gnt, 1'b1);
    tick();
    setP1(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);

    // Random traffic: requests held until granted, occasional reset.
    for (int c = 0; c < 3000; c++) begin
      if (!p0_req || lastG0) begin
        if ($urandom_range(0, 2) != 0)
          setP0(1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
        else
          p0_req = 1'b0;
      end
      if (!p1_req || lastG1) begin
        if ($urandom_range(0, 2) != 0)
          setP1(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                16'($urandom), 16'($urandom));
        else
          p1_req = 1'b0;
      end
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end

    reset = 1'b0;
    setP0(1'b0, 1'b0, 16'h0, 16'h0);
    setP1(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
